chromatic_input_ctrl: RTL
=========================

Name: chromatic_input_ctrl

Overview:
- Produces the control inputs consumed by the chromatic RGB matrix driver: a one-cycle `f_edge` colour-advance pulse and a `pwm_out` blanking stream.
- `f_edge` is derived from a debounced, active-low push button.
- `pwm_out` is a PWM signal whose duty is ramped up or down while a second button is held.
- Sits between the raw board buttons and the colour driver on the same clock. `pwm_out = 1` blanks every LED, because the driver ORs it into active-low colour lines.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a button level change (10 ms at 50 MHz); must be ≥ 2.
- PWM_BITS, 8, width of the PWM counter and duty register; MAX = 2^PWM_BITS-1.
- STEP_CYCLES, 2000000, cycles between duty steps while the dim button is held; must be ≥ 1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- btn_n  input  1  raw colour button, active-low, asynchronous to clk
- dim_n  input  1  raw dim button, active-low, asynchronous to clk
- up_down  input  1  ramp direction while dim is held: 1 = brighter, 0 = dimmer
- f_edge  output  1  one-cycle pulse on each accepted colour-button press
- pwm_out  output  1  1 = blank LEDs, 0 = LEDs enabled
- duty  output  PWM_BITS  duty currently applied to pwm_out

Behaviour:
- One clock, `clk`. Reset `rst` is synchronous, active-high, and overrides everything. A reset mid-operation discards pending debounce counts, step counts and duty requests.
- Reset values:
  - synchronizer flops = 1
  - debounced levels = 1 (released)
  - f_edge = 0
  - pwm_out = 1
  - duty = MAX, duty_req = MAX
  - PWM counter = 0, step counter = 0
- Synchronisation: each of `btn_n` and `dim_n` passes through a 2-flop synchronizer before any other logic.
- Debounce FSM, one instance per button. States: REL (stable 1), CHK_PRESS, PRS (stable 0), CHK_REL.
  - REL → CHK_PRESS when the sync input is 0; the counter loads 1.
  - CHK_PRESS: a sync input of 1 returns to REL and clears the counter. Otherwise the counter increments; on reaching DEBOUNCE_CYCLES, go to PRS and pulse `fall` for one cycle.
  - PRS ↔ CHK_REL is symmetric, with a `rise` pulse.
  - Any bounce inside a CHK state restarts the full count.
- f_edge is the registered `fall` of the colour button. It is high for exactly one cycle, DEBOUNCE_CYCLES+3 edges after the first edge that samples `btn_n` low. Release produces no pulse. A held button produces exactly one pulse.
- Step timer:
  - Runs only while the debounced dim level is 0; otherwise it is held at 0.
  - Counts 0..STEP_CYCLES-1 and issues a one-cycle `tick` on the wrap.
  - The first tick occurs STEP_CYCLES cycles after the debounced press.
- Duty request:
  - On a tick, duty_req += 1 if up_down = 1, else duty_req -= 1.
  - Saturates at MAX and at 0; it never wraps.
  - `up_down` is sampled only on ticks.
- PWM generation:
  - The PWM counter free-runs, incrementing every cycle and wrapping MAX → 0.
  - `duty` loads duty_req only on the cycle the counter wraps MAX → 0, so the duty changes only at period boundaries.
  - If a tick and the wrap coincide, `duty` loads the pre-tick duty_req; the new value applies from the following period.
- pwm_out is registered:
  - pwm_out = 1 when counter ≥ duty and duty ≠ MAX; otherwise 0.
  - duty = MAX gives continuous 0 (full on). duty = 0 gives continuous 1 (dark).
  - Otherwise the output is low for exactly `duty` cycles of each 2^PWM_BITS-cycle period.
- Both buttons are fully independent; simultaneous activity has no interaction.

Decomposition:
- Shared package holds:
  - the debounce state encoding (REL, CHK_PRESS, PRS, CHK_REL)
  - the default DEBOUNCE_CYCLES / STEP_CYCLES constants
  - the LED count constant (25) shared with the colour driver
- One sub-module, `btn_debounce`: synchronizer, FSM and counter, with outputs level/fall/rise. It is instantiated twice.

Test Plan (DEBOUNCE_CYCLES=4, STEP_CYCLES=3, PWM_BITS=4, MAX=15):
- Reset, then idle 40 cycles → f_edge = 0, duty = 15, pwm_out = 0 throughout after the first post-reset cycle.
- btn_n held low 20 cycles → single f_edge pulse exactly 7 edges after the first low sample; no pulse on release.
- btn_n toggled low/high every 2 cycles for 30 cycles, then held high → no f_edge.
- dim_n held low, up_down = 0 → duty_req falls 15→14→13… one step per 3 cycles and stops at 0. `duty` changes only on wraps. At duty = 0, pwm_out = 1 continuously.
- duty = 5 steady → pwm_out low exactly 5 of every 16 cycles. Then up_down = 1 with dim held → duty saturates at 15 and pwm_out stays 0.
- Assert rst mid-debounce and mid-ramp → next cycle all outputs at reset values; a following 3-cycle btn_n press gives no f_edge.

Source files
------------

// File: rtl/chromatic_input_ctrl_pkg.sv
// Shared types and constants for the chromatic RGB matrix input controller.
package chromatic_input_ctrl_pkg;

    // Debounce FSM states: stable released, checking press, stable pressed, checking release.
    typedef enum logic [1:0] {
        REL       = 2'd0,
        CHK_PRESS = 2'd1,
        PRS       = 2'd2,
        CHK_REL   = 2'd3
    } db_state_e;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;   // 10 ms at 50 MHz
    localparam int unsigned STEP_CYCLES_DEF     = 2000000;  // duty step interval while dimming
    localparam int unsigned PWM_BITS_DEF        = 8;
    localparam int unsigned LED_COUNT           = 25;       // matrix size shared with the colour driver

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus debounce FSM for one active-low button.
// level_o is the debounced level; fall_o/rise_o pulse once per accepted change.
module btn_debounce
    import chromatic_input_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n_i,
    output logic level_o,
    output logic fall_o,
    output logic rise_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1_q;
    logic             sync2_q;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             fall_q, fall_d;
    logic             rise_q, rise_d;

    // Bring the asynchronous button into the clk domain; idle level is released (1).
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
        end
    end

    // FSM state, stability counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= REL;
            cnt_q   <= '0;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            fall_q  <= fall_d;
            rise_q  <= rise_d;
        end
    end

    // Next state: any bounce inside a CHK state drops back and restarts the full count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        fall_d  = 1'b0;
        rise_d  = 1'b0;
        case (state_q)
            REL: begin
                if (!sync2_q) begin
                    state_d = CHK_PRESS;
                    cnt_d   = CNT_ONE;
                end
            end
            CHK_PRESS: begin
                if (sync2_q) begin
                    state_d = REL;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_DONE) begin
                    state_d = PRS;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRS: begin
                if (sync2_q) begin
                    state_d = CHK_REL;
                    cnt_d   = CNT_ONE;
                end
            end
            CHK_REL: begin
                if (!sync2_q) begin
                    state_d = PRS;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_DONE) begin
                    state_d = REL;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = REL;
                cnt_d   = '0;
                level_d = 1'b1;
            end
        endcase
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/chromatic_input_ctrl.sv
// Button front-end for the chromatic matrix driver: colour-advance pulse and
// a ramped PWM blanking stream (pwm_out = 1 blanks every LED).
module chromatic_input_ctrl
    import chromatic_input_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned PWM_BITS        = PWM_BITS_DEF,
    parameter int unsigned STEP_CYCLES     = STEP_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_n,
    input  logic                dim_n,
    input  logic                up_down,
    output logic                f_edge,
    output logic                pwm_out,
    output logic [PWM_BITS-1:0] duty
);

    localparam int unsigned STEP_W = $clog2(STEP_CYCLES + 1);
    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_CYCLES - 1);
    localparam logic [STEP_W-1:0]   STEP_ONE  = STEP_W'(1);
    localparam logic [PWM_BITS-1:0] PWM_MAX   = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] PWM_ONE   = PWM_BITS'(1);

    logic btn_fall;
    logic unused_btn_level;
    logic unused_btn_rise;
    logic dim_level;
    logic unused_dim_fall;
    logic unused_dim_rise;

    logic                tick_c;
    logic                wrap_c;
    logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
    logic [PWM_BITS-1:0] duty_req_q, duty_req_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                pwm_q, pwm_d;
    logic                f_edge_q, f_edge_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_db (
        .clk    (clk),
        .rst    (rst),
        .btn_n_i(btn_n),
        .level_o(unused_btn_level),
        .fall_o (btn_fall),
        .rise_o (unused_btn_rise)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_dim_db (
        .clk    (clk),
        .rst    (rst),
        .btn_n_i(dim_n),
        .level_o(dim_level),
        .fall_o (unused_dim_fall),
        .rise_o (unused_dim_rise)
    );

    // Step tick fires on the step-timer wrap while dim is held; PWM period ends at counter MAX.
    assign tick_c = !dim_level && (step_cnt_q == STEP_LAST);
    assign wrap_c = (pwm_cnt_q == PWM_MAX);

    // Next-state datapath for step timer, saturating duty request and PWM.
    always_comb begin
        step_cnt_d = step_cnt_q;
        duty_req_d = duty_req_q;
        pwm_cnt_d  = pwm_cnt_q + PWM_ONE;
        duty_d     = duty_q;
        pwm_d      = (pwm_cnt_q >= duty_q) && (duty_q != PWM_MAX);
        f_edge_d   = btn_fall;

        if (dim_level || tick_c) begin
            step_cnt_d = '0;
        end else begin
            step_cnt_d = step_cnt_q + STEP_ONE;
        end

        if (tick_c) begin
            if (up_down && (duty_req_q != PWM_MAX)) begin
                duty_req_d = duty_req_q + PWM_ONE;
            end else if (!up_down && (duty_req_q != '0)) begin
                duty_req_d = duty_req_q - PWM_ONE;
            end
        end

        // Duty only moves at period boundaries; a coincident tick lands next period.
        if (wrap_c) begin
            duty_d = duty_req_q;
        end
    end

    // Registered state; reset leaves the LEDs blanked with full duty pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_cnt_q <= '0;
            duty_req_q <= PWM_MAX;
            pwm_cnt_q  <= '0;
            duty_q     <= PWM_MAX;
            pwm_q      <= 1'b1;
            f_edge_q   <= 1'b0;
        end else begin
            step_cnt_q <= step_cnt_d;
            duty_req_q <= duty_req_d;
            pwm_cnt_q  <= pwm_cnt_d;
            duty_q     <= duty_d;
            pwm_q      <= pwm_d;
            f_edge_q   <= f_edge_d;
        end
    end

    assign f_edge  = f_edge_q;
    assign pwm_out = pwm_q;
    assign duty    = duty_q;

endmodule
